ps2_input: RTL and testbench
============================

Name: ps2_input

Overview:
- Converts a PS/2 keyboard stream into the 8-bit input byte that the peripheral unit drives onto BUS when the core executes an IN.
- Sits directly upstream of the peripheral unit and replaces its raw KBCLK/KBDTA handling.
- Produces ASCII for printable keys, game-controller codes for the arrow keys, and 0xFF when idle.
- Holds each keypress for a minimum number of video frames so the ROM's once-per-frame input poll cannot miss it.

Parameters:
- TIMEOUT_CYCLES, 6500: CLK cycles with no KBCLK falling edge before a partial frame is aborted (1 ms at 6.5 MHz).
- FILTER_LEN, 4: consecutive identical synchronised samples required to accept a KBCLK level change.
- MIN_FRAMES, 2: VSYNC falling edges a code must be presented before release is allowed.

Ports:
- CLK  in  1  core clock, 6.5 MHz.
- RST  in  1  asynchronous, active-high reset.
- KBCLK  in  1  PS/2 clock, asynchronous, open-collector.
- KBDTA  in  1  PS/2 data, asynchronous.
- VSYNC  in  1  OUT[7], active-low frame sync from the core.
- IN_BYTE  out  8  value driven to BUS on IE.
- KEY_VALID  out  1  high while IN_BYTE != 0xFF.
- FRAME_ERR  out  1  one-cycle pulse on a parity, start, stop or timeout error.

Behaviour:
- Reset (asynchronous, active-high) values:
  - IN_BYTE=0xFF, KEY_VALID=0, FRAME_ERR=0.
  - All FSMs in IDLE; shift, e0, f0 and release flags cleared.
- Input synchronisation and filtering:
  - KBCLK, KBDTA and VSYNC each pass through a 2-flop synchroniser.
  - KBCLK is further debounced by FILTER_LEN samples.
  - KBDTA is sampled on the cycle the filtered KBCLK falling edge is detected.
- Receive FSM: IDLE -> DATA -> PARITY -> STOP -> IDLE.
  - IDLE: on a falling edge, KBDTA must be 0 (start bit). If KBDTA=1, pulse FRAME_ERR and stay in IDLE.
  - DATA: 8 bits, LSB first; a 3-bit counter wraps 7 -> 0 and moves to PARITY.
  - PARITY: the parity bit plus the 8 data bits must contain an odd number of ones.
  - STOP: KBDTA must be 1. If the frame is good, the scan byte goes to the decoder, 1 cycle after the stop edge. Any error pulses FRAME_ERR and discards the byte.
  - A timeout counter resets on every edge. When it reaches TIMEOUT_CYCLES in any non-IDLE state, the FSM returns to IDLE and pulses FRAME_ERR. No counter runs in IDLE.
- Decoder, one byte per cycle:
  - 0xE0 sets e0. 0xF0 sets f0.
  - Any other byte is a make (f0=0) or a break (f0=1); e0 and f0 clear after that byte.
  - 0x12 and 0x59 make/break update lshift and rshift. shift = lshift | rshift.
- Keymap (sub-module, combinational), inputs {e0, shift, scan}:
  - Letters: 0x1C -> 'a'=0x61, or 'A'=0x41 with shift.
  - Digits: 0x16 -> '1'=0x31, or '!'=0x21 with shift.
  - Space 0x29 -> 0x20; Enter 0x5A -> 0x0A; Backspace 0x66 -> 0x7F; Esc 0x76 -> 0x1B.
  - Arrows (e0): E0 74 -> 0xFE, E0 6B -> 0xFD, E0 72 -> 0xFB, E0 75 -> 0xF7.
  - Unmapped scan codes produce no output (ignored).
- Hold logic:
  - Mapped make:
    - IN_BYTE <= code, held_sc <= {e0, scan}, frames_left <= MIN_FRAMES, release_pend <= 0.
    - This applies even when another key is already held, so the new key replaces the old one.
  - Typematic repeat (make of held_sc): IN_BYTE is unchanged and release_pend is cleared.
  - Break of held_sc: release_pend <= 1. A break of any other key is ignored.
  - frames_left decrements on each synchronised VSYNC falling edge and saturates at 0.
  - When release_pend=1 and frames_left=0: IN_BYTE <= 0xFF on the next cycle and release_pend clears.
  - A shift change while a key is held does not alter IN_BYTE.
  - KEY_VALID = (IN_BYTE != 0xFF), registered together with IN_BYTE.
- Reset mid-frame aborts the frame silently: no FRAME_ERR pulse.

Decomposition:
- Shared package ps2_pkg holds:
  - scan constants: SC_E0, SC_F0, SC_LSHIFT, SC_RSHIFT;
  - game-controller codes: BTN_RIGHT=0xFE, BTN_LEFT=0xFD, BTN_DOWN=0xFB, BTN_UP=0xF7;
  - IDLE_BYTE=0xFF;
  - the receive-state enum.
- One sub-module, ps2_keymap: the combinational scan -> code ROM with a valid flag.

Test Plan:
- Frame 1C (a make), then 2 VSYNC falls, then F0 1C -> IN_BYTE=0x61 one cycle after the stop edge; it returns to 0xFF one cycle after the break completes.
- 12, 1C, F0 1C within the same frame, no VSYNC edges yet -> IN_BYTE=0x41 is held until the 2nd VSYNC fall, then goes to 0xFF.
- E0 75, then E0 F0 75 -> IN_BYTE=0xF7, later 0xFF; KEY_VALID tracks IN_BYTE.
- Byte 1C sent with even parity -> FRAME_ERR pulses once and IN_BYTE stays 0xFF.
- 5 bits sent, then clock idle for 6500 cycles -> FRAME_ERR pulses; the following valid 29 frame gives IN_BYTE=0x20.
- 1C held, then 16 made (no break of 1C) -> IN_BYTE=0x31 immediately; the later F0 1C is ignored.

Source files
------------

// File: rtl/ps2_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ps2_pkg                                                              |
// | Shared scan-code constants, controller codes and receive-state enum. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package ps2_pkg;

    localparam logic [7:0] SC_E0     = 8'hE0;
    localparam logic [7:0] SC_F0     = 8'hF0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;

    localparam logic [7:0] BTN_RIGHT = 8'hFE;
    localparam logic [7:0] BTN_LEFT  = 8'hFD;
    localparam logic [7:0] BTN_DOWN  = 8'hFB;
    localparam logic [7:0] BTN_UP    = 8'hF7;

    localparam logic [7:0] IDLE_BYTE = 8'hFF;

    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_DATA   = 2'd1,
        RX_PARITY = 2'd2,
        RX_STOP   = 2'd3
    } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/ps2_keymap.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ps2_keymap                                                           |
// | Combinational scan-code to ASCII / controller-code ROM.              |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module ps2_keymap
    import ps2_pkg::*;
(
    input  logic       e0,
    input  logic       shift,
    input  logic [7:0] scan,
    output logic [7:0] code,
    output logic       valid
);

    // Each entry packs {unshifted, shifted}; zero marks an unmapped code.
    logic [15:0] w_pair;

    always_comb begin
        w_pair = 16'h0000;
        case (scan)
            8'h1C: w_pair = 16'h6141;  8'h32: w_pair = 16'h6242;
            8'h21: w_pair = 16'h6343;  8'h23: w_pair = 16'h6444;
            8'h24: w_pair = 16'h6545;  8'h2B: w_pair = 16'h6646;
            8'h34: w_pair = 16'h6747;  8'h33: w_pair = 16'h6848;
            8'h43: w_pair = 16'h6949;  8'h3B: w_pair = 16'h6A4A;
            8'h42: w_pair = 16'h6B4B;  8'h4B: w_pair = 16'h6C4C;
            8'h3A: w_pair = 16'h6D4D;  8'h31: w_pair = 16'h6E4E;
            8'h44: w_pair = 16'h6F4F;  8'h4D: w_pair = 16'h7050;
            8'h15: w_pair = 16'h7151;  8'h2D: w_pair = 16'h7252;
            8'h1B: w_pair = 16'h7353;  8'h2C: w_pair = 16'h7454;
            8'h3C: w_pair = 16'h7555;  8'h2A: w_pair = 16'h7656;
            8'h1D: w_pair = 16'h7757;  8'h22: w_pair = 16'h7858;
            8'h35: w_pair = 16'h7959;  8'h1A: w_pair = 16'h7A5A;
            8'h16: w_pair = 16'h3121;  8'h1E: w_pair = 16'h3240;
            8'h26: w_pair = 16'h3323;  8'h25: w_pair = 16'h3424;
            8'h2E: w_pair = 16'h3525;  8'h36: w_pair = 16'h365E;
            8'h3D: w_pair = 16'h3726;  8'h3E: w_pair = 16'h382A;
            8'h46: w_pair = 16'h3928;  8'h45: w_pair = 16'h3029;
            8'h29: w_pair = 16'h2020;  8'h5A: w_pair = 16'h0A0A;
            8'h66: w_pair = 16'h7F7F;  8'h76: w_pair = 16'h1B1B;
            default: w_pair = 16'h0000;
        endcase
    end

    always_comb begin
        code  = IDLE_BYTE;
        valid = 1'b0;
        if (e0) begin
            case (scan)
                8'h74: begin code = BTN_RIGHT; valid = 1'b1; end
                8'h6B: begin code = BTN_LEFT;  valid = 1'b1; end
                8'h72: begin code = BTN_DOWN;  valid = 1'b1; end
                8'h75: begin code = BTN_UP;    valid = 1'b1; end
                default: begin code = IDLE_BYTE; valid = 1'b0; end
            endcase
        end else if (w_pair != 16'h0000) begin
            code  = shift ? w_pair[7:0] : w_pair[15:8];
            valid = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ps2_input.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ps2_input                                                            |
// | PS/2 receiver, decoder and frame-hold logic producing the IN byte.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module ps2_input
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 6500,
    parameter int FILTER_LEN     = 4,
    parameter int MIN_FRAMES     = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       KBCLK,
    input  logic       KBDTA,
    input  logic       VSYNC,
    output logic [7:0] IN_BYTE,
    output logic       KEY_VALID,
    output logic       FRAME_ERR
);

    localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int MW = (MIN_FRAMES > 0) ? $clog2(MIN_FRAMES + 1) : 1;

    logic [1:0]    r_kbclk_sync;
    logic [1:0]    r_kbdta_sync;
    logic [2:0]    r_vsync_sync;
    logic          r_kbclk_filt;
    logic [FW-1:0] r_filt_cnt;
    logic          w_filt_accept;
    logic          w_fall;
    logic          w_dta;
    logic          w_vs_fall;

    // Synchronisers idle high so reset never manufactures an edge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_kbclk_sync <= 2'b11;
            r_kbdta_sync <= 2'b11;
            r_vsync_sync <= 3'b111;
            r_kbclk_filt <= 1'b1;
            r_filt_cnt   <= '0;
        end else begin
            r_kbclk_sync <= {r_kbclk_sync[0], KBCLK};
            r_kbdta_sync <= {r_kbdta_sync[0], KBDTA};
            r_vsync_sync <= {r_vsync_sync[1:0], VSYNC};
            if (r_kbclk_sync[1] == r_kbclk_filt) begin
                r_filt_cnt <= '0;
            end else if (w_filt_accept) begin
                r_kbclk_filt <= r_kbclk_sync[1];
                r_filt_cnt   <= '0;
            end else begin
                r_filt_cnt <= r_filt_cnt + 1'b1;
            end
        end
    end

    assign w_filt_accept = (r_filt_cnt == FW'(FILTER_LEN - 1));
    assign w_fall        = r_kbclk_filt && !r_kbclk_sync[1] && w_filt_accept;
    assign w_dta         = r_kbdta_sync[1];
    assign w_vs_fall     = r_vsync_sync[2] && !r_vsync_sync[1];

    rx_state_t     r_state;
    logic [2:0]    r_bitcnt;
    logic [7:0]    r_shreg;
    logic          r_par_ok;
    logic [TW-1:0] r_tmo;
    logic          r_scan_vld;
    logic [7:0]    r_scan;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state    <= RX_IDLE;
            r_bitcnt   <= 3'd0;
            r_shreg    <= 8'h00;
            r_par_ok   <= 1'b0;
            r_tmo      <= '0;
            r_scan_vld <= 1'b0;
            r_scan     <= 8'h00;
            FRAME_ERR  <= 1'b0;
        end else begin
            FRAME_ERR  <= 1'b0;
            r_scan_vld <= 1'b0;
            if (r_state == RX_IDLE || w_fall) begin
                r_tmo <= '0;
            end else begin
                r_tmo <= r_tmo + 1'b1;
            end

            if (r_state != RX_IDLE && !w_fall && r_tmo == TW'(TIMEOUT_CYCLES - 1)) begin
                r_state   <= RX_IDLE;
                FRAME_ERR <= 1'b1;
            end else if (w_fall) begin
                case (r_state)
                    RX_IDLE: begin
                        if (w_dta) begin
                            FRAME_ERR <= 1'b1;
                        end else begin
                            r_state  <= RX_DATA;
                            r_bitcnt <= 3'd0;
                        end
                    end
                    RX_DATA: begin
                        r_shreg  <= {w_dta, r_shreg[7:1]};
                        r_bitcnt <= r_bitcnt + 3'd1;
                        if (r_bitcnt == 3'd7) begin
                            r_state <= RX_PARITY;
                        end
                    end
                    RX_PARITY: begin
                        r_par_ok <= ^{r_shreg, w_dta};
                        r_state  <= RX_STOP;
                    end
                    RX_STOP: begin
                        r_state <= RX_IDLE;
                        if (w_dta && r_par_ok) begin
                            r_scan     <= r_shreg;
                            r_scan_vld <= 1'b1;
                        end else begin
                            FRAME_ERR <= 1'b1;
                        end
                    end
                    default: r_state <= RX_IDLE;
                endcase
            end
        end
    end

    logic          r_e0;
    logic          r_f0;
    logic          r_lshift;
    logic          r_rshift;
    logic          r_held_act;
    logic [8:0]    r_held_sc;
    logic [MW-1:0] r_frames_left;
    logic          r_release_pend;
    logic [7:0]    w_code;
    logic          w_mapped;
    logic          w_is_held;

    ps2_keymap u_keymap (
        .e0    (r_e0),
        .shift (r_lshift | r_rshift),
        .scan  (r_scan),
        .code  (w_code),
        .valid (w_mapped)
    );

    assign w_is_held = r_held_act && (r_held_sc == {r_e0, r_scan});

    // Later assignments win: a fresh make overrides a same-cycle release.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_e0           <= 1'b0;
            r_f0           <= 1'b0;
            r_lshift       <= 1'b0;
            r_rshift       <= 1'b0;
            r_held_act     <= 1'b0;
            r_held_sc      <= 9'h000;
            r_frames_left  <= '0;
            r_release_pend <= 1'b0;
            IN_BYTE        <= IDLE_BYTE;
            KEY_VALID      <= 1'b0;
        end else begin
            if (w_vs_fall && r_frames_left != '0) begin
                r_frames_left <= r_frames_left - 1'b1;
            end
            if (r_release_pend && r_frames_left == '0) begin
                IN_BYTE        <= IDLE_BYTE;
                KEY_VALID      <= 1'b0;
                r_release_pend <= 1'b0;
                r_held_act     <= 1'b0;
            end
            if (r_scan_vld) begin
                if (r_scan == SC_E0) begin
                    r_e0 <= 1'b1;
                end else if (r_scan == SC_F0) begin
                    r_f0 <= 1'b1;
                end else begin
                    r_e0 <= 1'b0;
                    r_f0 <= 1'b0;
                    if (r_scan == SC_LSHIFT) r_lshift <= ~r_f0;
                    if (r_scan == SC_RSHIFT) r_rshift <= ~r_f0;
                    if (!r_f0) begin
                        if (w_mapped) begin
                            if (w_is_held) begin
                                r_release_pend <= 1'b0;
                            end else begin
                                IN_BYTE        <= w_code;
                                KEY_VALID      <= (w_code != IDLE_BYTE);
                                r_held_sc      <= {r_e0, r_scan};
                                r_held_act     <= 1'b1;
                                r_frames_left  <= MW'(MIN_FRAMES);
                                r_release_pend <= 1'b0;
                            end
                        end
                    end else if (w_is_held) begin
                        r_release_pend <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ps2_input.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_ps2_input                                                         |
// | Randomised scoreboard bench with an event-level keyboard model.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_ps2_input;

    localparam int HALF = 12;
    localparam int TMO  = 6500;

    logic       CLK = 1'b0;
    logic       RST;
    logic       KBCLK;
    logic       KBDTA;
    logic       VSYNC;
    logic [7:0] IN_BYTE;
    logic       KEY_VALID;
    logic       FRAME_ERR;

    always #5 CLK = ~CLK;

    ps2_input dut (
        .CLK       (CLK),
        .RST       (RST),
        .KBCLK     (KBCLK),
        .KBDTA     (KBDTA),
        .VSYNC     (VSYNC),
        .IN_BYTE   (IN_BYTE),
        .KEY_VALID (KEY_VALID),
        .FRAME_ERR (FRAME_ERR)
    );

    typedef struct packed {
        logic       is_err;
        logic [7:0] val;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;

    // Keyboard model state, tracked per received byte and per frame pulse.
    bit         m_e0, m_f0, m_ls, m_rs, m_held_act, m_rp;
    logic [8:0] m_held;
    int         m_frames;
    logic [7:0] m_cur = 8'hFF;

    logic [7:0] letter_sc[26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
                                  8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31,
                                  8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C,
                                  8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    logic [7:0] digit_sc[10]  = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                                  8'h3E, 8'h46, 8'h45};
    string      dig_str = "1234567890";
    string      dsh_str = "!@#$%^&*()";
    logic [8:0] pool[16]      = '{9'h01C, 9'h032, 9'h021, 9'h04D, 9'h016, 9'h01E,
                                  9'h045, 9'h046, 9'h029, 9'h05A, 9'h066, 9'h076,
                                  9'h174, 9'h16B, 9'h172, 9'h175};
    logic [8:0] unmapped[4]   = '{9'h005, 9'h00D, 9'h15A, 9'h074};

    task automatic map_key(input bit e0, input bit sh, input logic [7:0] sc,
                           output bit ok, output logic [7:0] code);
        ok   = 1'b0;
        code = 8'hFF;
        if (e0) begin
            case (sc)
                8'h74: begin ok = 1'b1; code = 8'hFE; end
                8'h6B: begin ok = 1'b1; code = 8'hFD; end
                8'h72: begin ok = 1'b1; code = 8'hFB; end
                8'h75: begin ok = 1'b1; code = 8'hF7; end
                default: ok = 1'b0;
            endcase
        end else begin
            for (int i = 0; i < 26; i++)
                if (sc == letter_sc[i]) begin
                    ok = 1'b1; code = (sh ? 8'h41 : 8'h61) + 8'(i);
                end
            for (int i = 0; i < 10; i++)
                if (sc == digit_sc[i]) begin
                    ok = 1'b1; code = sh ? dsh_str[i] : dig_str[i];
                end
            if (sc == 8'h29) begin ok = 1'b1; code = 8'h20; end
            if (sc == 8'h5A) begin ok = 1'b1; code = 8'h0A; end
            if (sc == 8'h66) begin ok = 1'b1; code = 8'h7F; end
            if (sc == 8'h76) begin ok = 1'b1; code = 8'h1B; end
        end
    endtask

    task automatic push_byte(input logic [7:0] v);
        if (v != m_cur) begin
            m_cur = v;
            expq.push_back({1'b0, v});
        end
    endtask

    task automatic push_err();
        expq.push_back({1'b1, 8'h00});
    endtask

    task automatic model_settle();
        if (m_rp && m_frames == 0) begin
            m_rp = 1'b0;
            m_held_act = 1'b0;
            push_byte(8'hFF);
        end
    endtask

    task automatic model_byte(input logic [7:0] sc);
        bit         ok;
        logic [7:0] code;
        if (sc == 8'hE0) m_e0 = 1'b1;
        else if (sc == 8'hF0) m_f0 = 1'b1;
        else begin
            map_key(m_e0, m_ls | m_rs, sc, ok, code);
            if (!m_f0) begin
                if (ok) begin
                    if (m_held_act && m_held == {m_e0, sc}) m_rp = 1'b0;
                    else begin
                        push_byte(code);
                        m_held = {m_e0, sc}; m_held_act = 1'b1;
                        m_frames = 2; m_rp = 1'b0;
                    end
                end
            end else if (m_held_act && m_held == {m_e0, sc}) m_rp = 1'b1;
            if (sc == 8'h12) m_ls = !m_f0;
            if (sc == 8'h59) m_rs = !m_f0;
            m_e0 = 1'b0;
            m_f0 = 1'b0;
        end
        model_settle();
    endtask

    task automatic model_reset();
        m_e0 = 0; m_f0 = 0; m_ls = 0; m_rs = 0; m_held_act = 0; m_rp = 0;
        m_held = '0; m_frames = 0;
        push_byte(8'hFF);
    endtask

    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            KBDTA = bits[i];
            repeat (HALF) @(posedge CLK);
            KBCLK = 1'b0;
            repeat (HALF) @(posedge CLK);
            KBCLK = 1'b1;
        end
        KBDTA = 1'b1;
        repeat (2 * HALF) @(posedge CLK);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        if (bad_par || bad_stop) push_err();
        else model_byte(b);
        send_bits({~bad_stop, (~^b) ^ bad_par, b, 1'b0}, 11);
    endtask

    task automatic key(input logic [8:0] k, input bit brk);
        if (k[8]) send_byte(8'hE0, 1'b0, 1'b0);
        if (brk)  send_byte(8'hF0, 1'b0, 1'b0);
        send_byte(k[7:0], 1'b0, 1'b0);
    endtask

    task automatic vsync_pulse();
        if (m_frames > 0) m_frames--;
        model_settle();
        VSYNC = 1'b0;
        repeat (8) @(posedge CLK);
        VSYNC = 1'b1;
        repeat (8) @(posedge CLK);
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic pop_check(input bit is_err, input logic [7:0] v);
        exp_t e;
        checks++;
        if (expq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_%s actual=%h required=no_event",
                     is_err ? "frame_err" : "in_byte", v);
        end else begin
            e = expq.pop_front();
            if (e.is_err != is_err || (!is_err && e.val !== v)) begin
                errors++;
                $display("FAIL scoreboard actual=%s:%h required=%s:%h",
                         is_err ? "frame_err" : "in_byte", v,
                         e.is_err ? "frame_err" : "in_byte", e.val);
            end
        end
    endtask

    logic [7:0] prev_byte = 8'hFF;

    always @(negedge CLK) begin
        if (mon_en) begin
            if (FRAME_ERR === 1'b1) pop_check(1'b1, 8'h00);
            if (IN_BYTE !== prev_byte) begin
                pop_check(1'b0, IN_BYTE);
                checks++;
                if (KEY_VALID !== (IN_BYTE != 8'hFF)) begin
                    errors++;
                    $display("FAIL key_valid actual=%b required=%b", KEY_VALID, IN_BYTE != 8'hFF);
                end
            end
            prev_byte = IN_BYTE;
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1; KBCLK = 1'b1; KBDTA = 1'b1; VSYNC = 1'b1;
        model_reset();
        repeat (5) @(posedge CLK);
        #1;
        chk("reset_in_byte", IN_BYTE, 8'hFF);
        chk("reset_key_valid", {7'd0, KEY_VALID}, 8'h00);
        chk("reset_frame_err", {7'd0, FRAME_ERR}, 8'h00);
        RST = 1'b0;
        mon_en = 1'b1;
        repeat (5) @(posedge CLK);

        // a make, two frames, then break
        key(9'h01C, 1'b0);
        chk("make_a", IN_BYTE, 8'h61);
        vsync_pulse(); vsync_pulse();
        key(9'h01C, 1'b1);
        chk("break_a", IN_BYTE, 8'hFF);

        // shifted tap inside one frame is held for two frames
        key(9'h012, 1'b0);
        key(9'h01C, 1'b0);
        key(9'h01C, 1'b1);
        chk("hold_A_0", IN_BYTE, 8'h41);
        vsync_pulse();
        chk("hold_A_1", IN_BYTE, 8'h41);
        vsync_pulse();
        chk("hold_A_2", IN_BYTE, 8'hFF);
        key(9'h012, 1'b1);

        // arrow up
        key(9'h175, 1'b0);
        chk("arrow_up", IN_BYTE, 8'hF7);
        key(9'h175, 1'b1);
        vsync_pulse(); vsync_pulse();
        chk("arrow_rel", IN_BYTE, 8'hFF);

        // parity error
        send_byte(8'h1C, 1'b1, 1'b0);
        chk("bad_parity", IN_BYTE, 8'hFF);

        // partial frame then timeout, then recovery
        push_err();
        send_bits({6'h3F, 4'($urandom), 1'b0}, 5);
        repeat (TMO + 500) @(posedge CLK);
        key(9'h029, 1'b0);
        chk("after_timeout", IN_BYTE, 8'h20);
        key(9'h029, 1'b1);
        vsync_pulse(); vsync_pulse();

        // second key replaces first; stale break ignored
        key(9'h01C, 1'b0);
        key(9'h016, 1'b0);
        chk("replace", IN_BYTE, 8'h31);
        key(9'h01C, 1'b1);
        vsync_pulse(); vsync_pulse();
        chk("stale_break", IN_BYTE, 8'h31);
        key(9'h016, 1'b1);
        chk("replace_rel", IN_BYTE, 8'hFF);

        for (int it = 0; it < 50; it++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 35)      key(pool[$urandom_range(0, 15)], 1'b0);
            else if (r < 60) key(pool[$urandom_range(0, 15)], 1'b1);
            else if (r < 77) vsync_pulse();
            else if (r < 83) key($urandom_range(0, 1) ? 9'h012 : 9'h059, 1'($urandom_range(0, 1)));
            else if (r < 88) begin
                bit bp;
                bp = 1'($urandom_range(0, 1));
                send_byte(8'($urandom), bp, !bp);
            end
            else if (r < 92) begin
                push_err();
                send_bits(11'h7FF, 1);
            end
            else key(unmapped[$urandom_range(0, 3)], 1'($urandom_range(0, 1)));
        end

        // reset during a partial frame: silent abort
        key(9'h032, 1'b0);
        send_bits({7'h7F, 4'h0}, 4);
        model_reset();
        #3 RST = 1'b1;
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;
        repeat (5) @(posedge CLK);
        key(9'h029, 1'b0);
        chk("post_reset", IN_BYTE, 8'h20);

        repeat (100) @(posedge CLK);
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL pending_events actual=%0d required=0", expq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
